// File: rtl/hdlverifier_segmented_capture_if.sv
// Bus bundle for the segmented capture engine: sample stream, capture
// configuration, readout port and status flags.
interface hdlverifier_segmented_capture_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int SEG_LOG2_MAX = 3
);
  logic                    clk_enable;
  logic [DATA_WIDTH-1:0]   data;
  logic                    trigger;
  logic                    run;
  logic                    immediate;
  logic [2:0]              seg_log2;
  logic [ADDR_WIDTH-1:0]   trigger_pos;
  logic [7:0]              trigger_skip;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    busy;
  logic                    flag_full;
  logic [SEG_LOG2_MAX:0]   seg_done;

  modport master (
    output clk_enable, data, trigger, run, immediate, seg_log2,
           trigger_pos, trigger_skip, rd_addr,
    input  rd_data, busy, flag_full, seg_done
  );

  modport slave (
    input  clk_enable, data, trigger, run, immediate, seg_log2,
           trigger_pos, trigger_skip, rd_addr,
    output rd_data, busy, flag_full, seg_done
  );
endinterface

// File: rtl/hdlverifier_segmented_capture.sv
// Multi-segment capture engine: records qualified samples into a circular
// buffer split into 2^s segments, one trigger per segment, with a
// programmable pre-trigger depth and trigger skip count. Readout returns
// each segment in chronological order.
module hdlverifier_segmented_capture #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int SEG_LOG2_MAX = 3
) (
  input logic clk,
  input logic reset_tck,
  hdlverifier_segmented_capture_if.slave bus
);
  localparam int         NSEG    = 2 ** SEG_LOG2_MAX;
  localparam logic [2:0] LP_SMAX = 3'(SEG_LOG2_MAX);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  logic [1:0]              r_rst_sync;
  logic                    w_rst;
  logic                    r_vld_p0;
  logic [DATA_WIDTH-1:0]   r_data_p0;
  logic                    r_trig_p0;
  state_t                  r_state;
  logic                    r_run_q;
  logic                    r_busy;
  logic                    r_flag_full;
  logic [SEG_LOG2_MAX:0]   r_seg_done;
  logic [2:0]              r_s;
  logic [ADDR_WIDTH-1:0]   r_mask;
  logic [ADDR_WIDTH-1:0]   r_pos;
  logic [7:0]              r_skip;
  logic                    r_imm;
  logic [SEG_LOG2_MAX-1:0] r_k;
  logic [ADDR_WIDTH-1:0]   r_woff;
  logic [ADDR_WIDTH-1:0]   r_toff;
  logic [ADDR_WIDTH:0]     r_cnt;
  logic [7:0]              r_tcnt;
  logic [ADDR_WIDTH-1:0]   r_start_off [NSEG];
  logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]   r_rd_data;

  logic [2:0]              w_s;
  logic [ADDR_WIDTH-1:0]   w_mask;
  logic [ADDR_WIDTH-1:0]   w_pos;
  logic [ADDR_WIDTH:0]     w_post_len;
  logic [ADDR_WIDTH:0]     w_cnt_inc;
  logic                    w_active;
  logic                    w_we;
  logic                    w_hit;
  logic                    w_last;
  logic                    w_seg_end;
  logic [ADDR_WIDTH-1:0]   w_end_toff;
  logic [ADDR_WIDTH-1:0]   w_waddr;
  logic [SEG_LOG2_MAX-1:0] w_rk;
  logic [ADDR_WIDTH-1:0]   w_raddr;

  // Configuration as it would be latched on the arming edge
  assign w_s    = (bus.seg_log2 > LP_SMAX) ? LP_SMAX : bus.seg_log2;
  assign w_mask = {ADDR_WIDTH{1'b1}} >> w_s;
  assign w_pos  = bus.trigger_pos & w_mask;

  // Post-trigger length D-P (includes the trigger sample itself)
  assign w_post_len = {1'b0, r_mask} + (ADDR_WIDTH+1)'(1) - {1'b0, r_pos};
  assign w_cnt_inc  = r_cnt + (ADDR_WIDTH+1)'(1);
  assign w_active   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_we       = w_active && bus.run && r_vld_p0;
  assign w_hit      = r_imm || (r_trig_p0 && (r_tcnt == r_skip));
  assign w_last     = (({1'b0, r_k} + (SEG_LOG2_MAX+1)'(1)) == ((SEG_LOG2_MAX+1)'(1) << r_s));

  // Segment base k*D is k shifted into the top s address bits
  assign w_waddr = ADDR_WIDTH'({r_k, {ADDR_WIDTH{1'b0}}} >> r_s) | r_woff;

  // Readout: top s bits select the segment, low bits are rotated by its start offset
  assign w_rk    = SEG_LOG2_MAX'(({{SEG_LOG2_MAX{1'b0}}, bus.rd_addr} << r_s) >> ADDR_WIDTH);
  assign w_raddr = (bus.rd_addr & ~r_mask) | ((r_start_off[w_rk] + bus.rd_addr) & r_mask);

  // Detect the write that closes the current segment
  always_comb begin
    w_seg_end  = 1'b0;
    w_end_toff = r_toff;
    if (w_we) begin
      if ((r_state == S_WAIT) && w_hit && (w_post_len == (ADDR_WIDTH+1)'(1))) begin
        w_seg_end  = 1'b1;
        w_end_toff = r_woff;
      end else if ((r_state == S_POST) && (w_cnt_inc == w_post_len)) begin
        w_seg_end  = 1'b1;
      end
    end
  end

  // Reset assertion is immediate; release is delayed by two clk edges
  always_ff @(posedge clk or posedge reset_tck) begin
    if (reset_tck) r_rst_sync <= 2'b11;
    else           r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  // Sample stage p0: qualifier flag
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) r_vld_p0 <= 1'b0;
    else       r_vld_p0 <= bus.clk_enable;
  end

  // Sample stage p0: data and trigger travel with the qualifier
  always_ff @(posedge clk) begin
    r_data_p0 <= bus.data;
    r_trig_p0 <= bus.trigger;
  end

  // Capture FSM: arming, pre-trigger fill, trigger search, post fill, done
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= S_IDLE;
      r_run_q     <= 1'b1;
      r_busy      <= 1'b0;
      r_flag_full <= 1'b0;
      r_seg_done  <= '0;
      r_s         <= '0;
      r_mask      <= '0;
      r_pos       <= '0;
      r_skip      <= '0;
      r_imm       <= 1'b0;
      r_k         <= '0;
      r_woff      <= '0;
      r_toff      <= '0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      for (int i = 0; i < NSEG; i++) r_start_off[i] <= '0;
    end else begin
      r_run_q <= bus.run;
      unique case (r_state)
        S_IDLE: begin
          if (bus.run && !r_run_q) begin
            r_s         <= w_s;
            r_mask      <= w_mask;
            r_pos       <= w_pos;
            r_skip      <= bus.trigger_skip;
            r_imm       <= bus.immediate;
            r_k         <= '0;
            r_woff      <= '0;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_seg_done  <= '0;
            r_flag_full <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= (w_pos == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE, S_WAIT, S_POST: begin
          if (!bus.run) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_seg_done  <= '0;
            r_flag_full <= 1'b0;
          end else if (r_vld_p0) begin
            r_woff <= (r_woff + ADDR_WIDTH'(1)) & r_mask;
            if (r_state == S_PRE) begin
              if (w_cnt_inc == {1'b0, r_pos}) begin
                r_state <= S_WAIT;
                r_cnt   <= '0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else if (r_state == S_WAIT) begin
              if (w_hit) begin
                r_toff  <= r_woff;
                r_cnt   <= (ADDR_WIDTH+1)'(1);
                r_state <= S_POST;
              end else if (r_trig_p0) begin
                r_tcnt <= r_tcnt + 8'd1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
            if (w_seg_end) begin
              r_start_off[r_k] <= (w_end_toff - r_pos) & r_mask;
              r_seg_done       <= r_seg_done + (SEG_LOG2_MAX+1)'(1);
              r_cnt            <= '0;
              r_tcnt           <= '0;
              if (w_last) begin
                r_state     <= S_DONE;
                r_busy      <= 1'b0;
                r_flag_full <= 1'b1;
              end else begin
                r_k     <= r_k + SEG_LOG2_MAX'(1);
                r_state <= (r_pos == '0) ? S_WAIT : S_PRE;
              end
            end
          end
        end
        S_DONE: begin
          if (!bus.run) begin
            r_state     <= S_IDLE;
            r_flag_full <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer write port
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= r_data_p0;
  end

  // Buffer read port with registered output
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[w_raddr];
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.busy      = r_busy;
  assign bus.flag_full = r_flag_full;
  assign bus.seg_done  = r_seg_done;

endmodule

// File: tb/tb_hdlverifier_segmented_capture.sv
// Randomised bench for the segmented capture engine with a sample-index
// reference model: each segment's trigger index is derived from the trigger
// pattern, which fixes completion timing and readout contents.
module tb_hdlverifier_segmented_capture;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SM = 3;

  logic clk = 1'b0;
  logic reset_tck = 1'b0;

  hdlverifier_segmented_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEG_LOG2_MAX(SM)) bus ();

  hdlverifier_segmented_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEG_LOG2_MAX(SM)) dut (
    .clk      (clk),
    .reset_tck(reset_tck),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int idx    = 0;
  int phase  = 0;   // 0: idle expected, 1: capture model active, 2: unchecked
  int hist [0:16383];
  bit trg  [0:511];
  int m_trig [0:7];
  int m_end  [0:7];
  int m_nseg = 1;
  int m_D    = 16;
  int m_P    = 0;
  bit m_ok   = 1'b1;
  int n_seen;
  int n_exp;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: segment boundaries as sample indices
  function automatic void build_model(input int seg, input int pos, input int skip, input bit imm);
    int s, b, i, cnt, t;
    s      = (seg > SM) ? SM : seg;
    m_D    = 16 >> s;
    m_nseg = 1 << s;
    m_P    = pos & (m_D - 1);
    m_ok   = 1'b1;
    b      = 0;
    for (int k = 0; k < 8; k++) begin
      m_trig[k] = 1 << 20;
      m_end[k]  = 1 << 20;
    end
    for (int k = 0; k < m_nseg; k++) begin
      i = b + m_P;
      t = -1;
      if (imm) t = i;
      else begin
        cnt = 0;
        while (i < 500) begin
          if (trg[i]) begin
            if (cnt == skip) begin t = i; break; end
            cnt++;
          end
          i++;
        end
      end
      if (t < 0) begin m_ok = 1'b0; break; end
      m_trig[k] = t;
      m_end[k]  = t + (m_D - m_P) - 1;
      b         = m_end[k] + 1;
    end
  endfunction

  // Per-cycle status comparison against the model
  always @(negedge clk) begin
    if (phase == 0) begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_flag_full", bus.flag_full, 0);
      chk("idle_seg_done", bus.seg_done, 0);
    end else if (phase == 1 && cyc >= 1 && cyc < 16384) begin
      n_seen = hist[cyc-1];
      n_exp  = 0;
      for (int k = 0; k < m_nseg; k++) if (m_end[k] < n_seen) n_exp++;
      chk("seg_done", bus.seg_done, n_exp);
      chk("flag_full", bus.flag_full, (n_exp == m_nseg) ? 1 : 0);
      chk("busy", bus.busy, (n_exp < m_nseg) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 16384) hist[cyc] = idx;
    bus.clk_enable = 1'b0;
    bus.data       = $urandom;
    bus.trigger    = 1'($urandom_range(0, 1));
  endtask

  task automatic feed();
    step();
    if ($urandom_range(0, 99) < 60 && idx < 511) begin
      bus.clk_enable = 1'b1;
      bus.data       = idx;
      bus.trigger    = trg[idx];
      idx++;
    end
  endtask

  task automatic clear_trg();
    for (int i = 0; i < 512; i++) trg[i] = 1'b0;
  endtask

  task automatic rand_trg();
    for (int i = 0; i < 512; i++) trg[i] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic arm(input int seg, input int pos, input int skip, input bit imm);
    idx = 0;
    step();
    step();
    build_model(seg, pos, skip, imm);
    step();
    bus.seg_log2     = 3'(seg);
    bus.trigger_pos  = 4'(pos);
    bus.trigger_skip = 8'(skip);
    bus.immediate    = imm;
    bus.run          = 1'b1;
    step();
    phase = 1;
    step();
  endtask

  task automatic capture(input int seg, input int pos, input int skip, input bit imm,
                         input bit do_lit, input int lit_first, input int lit_last, input int lit_segs);
    int budget;
    int expv;
    arm(seg, pos, skip, imm);
    if (!m_ok) begin
      checks++;
      errors++;
      $display("FAIL model_setup: trigger pattern does not complete %0d segments", m_nseg);
    end
    budget = 0;
    while (idx <= m_end[m_nseg-1] && budget < 3000) begin
      feed();
      budget++;
    end
    checks++;
    if (budget >= 3000) begin
      errors++;
      $display("FAIL capture_budget: got %0d samples required %0d", idx, m_end[m_nseg-1] + 1);
    end
    repeat (3) step();
    chk("final_flag_full", bus.flag_full, 1);
    if (lit_segs > 0) chk("final_seg_done_lit", bus.seg_done, lit_segs);
    for (int a = 0; a < 16; a++) begin
      step();
      bus.rd_addr = 4'(a);
      step();
      #1;
      expv = m_trig[a / m_D] - m_P + (a % m_D);
      chk($sformatf("rd_data[%0d]", a), bus.rd_data, expv);
      if (do_lit && a == 0)  chk("rd_first_lit", bus.rd_data, lit_first);
      if (do_lit && a == 15) chk("rd_last_lit", bus.rd_data, lit_last);
    end
    step();
    bus.run = 1'b0;
    step();
    phase = 2;
  endtask

  initial begin
    int budget;
    bus.clk_enable   = 1'b0;
    bus.data         = '0;
    bus.trigger      = 1'b0;
    bus.run          = 1'b0;
    bus.immediate    = 1'b0;
    bus.seg_log2     = '0;
    bus.trigger_pos  = '0;
    bus.trigger_skip = '0;
    bus.rd_addr      = '0;
    for (int i = 0; i < 16384; i++) hist[i] = 0;
    clear_trg();

    // Power-up reset
    #2 reset_tck = 1'b1;
    repeat (3) step();
    chk("reset_rd_data", bus.rd_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_seg_done", bus.seg_done, 0);
    reset_tck = 1'b0;
    repeat (3) step();

    // Directed scenarios
    clear_trg(); trg[20] = 1'b1;
    capture(0, 4, 0, 1'b0, 1'b1, 16, 31, 1);
    clear_trg(); trg[10] = 1'b1; trg[20] = 1'b1; trg[30] = 1'b1; trg[40] = 1'b1;
    capture(2, 1, 0, 1'b0, 1'b1, 9, 42, 4);
    clear_trg(); trg[3] = 1'b1; trg[12] = 1'b1;
    capture(0, 8, 0, 1'b0, 1'b1, 4, 19, 1);
    clear_trg(); trg[10] = 1'b1; trg[12] = 1'b1; trg[14] = 1'b1;
    capture(0, 0, 2, 1'b0, 1'b1, 14, 29, 1);
    capture(0, 0, 2, 1'b1, 1'b1, 0, 15, 1);
    rand_trg();
    capture(7, 5, 1, 1'b0, 1'b0, 0, 0, 8);

    // Randomised configurations
    for (int r = 0; r < 4; r++) begin
      rand_trg();
      capture($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), 1'b0, 0, 0, 0);
    end

    // Abort during WAIT of the second segment
    clear_trg(); trg[5] = 1'b1;
    arm(1, 2, 0, 1'b0);
    budget = 0;
    while (idx < 26 && budget < 1000) begin feed(); budget++; end
    chk("abort_pre_seg_done", bus.seg_done, 1);
    step();
    bus.run = 1'b0;
    step();
    phase = 0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_seg_done", bus.seg_done, 0);
    repeat (4) step();

    // Reset pulse during POST, run held high afterwards
    clear_trg(); trg[6] = 1'b1;
    arm(0, 2, 0, 1'b0);
    budget = 0;
    while (idx < 12 && budget < 1000) begin feed(); budget++; end
    chk("post_busy_before_reset", bus.busy, 1);
    #2;
    reset_tck = 1'b1;
    phase = 0;
    #1;
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_flag_full", bus.flag_full, 0);
    chk("rst_async_seg_done", bus.seg_done, 0);
    chk("rst_async_rd_data", bus.rd_data, 0);
    repeat (2) step();
    reset_tck = 1'b0;
    repeat (12) feed();
    chk("rst_stays_idle", bus.busy, 0);
    bus.run = 1'b0;
    repeat (2) step();

    // Recovery capture after reset
    clear_trg(); trg[9] = 1'b1;
    capture(0, 3, 0, 1'b0, 1'b1, 6, 21, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
